// File: rtl/uart_tx_if.sv
// Parallel-side bundle of the UART transmitter: start/data in, busy/done/line out.
// The master drives start, tick and data; the slave (uart_tx) drives status and the line.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic            s_tick;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;
  logic            tx;

  modport master (
    output tx_start, s_tick, din,
    input  tx_busy, tx_done_tick, tx
  );

  modport slave (
    input  tx_start, s_tick, din,
    output tx_busy, tx_done_tick, tx
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB-first, optional parity, stop; paced by 16x s_tick.
// tx drops 1 clk after an accepted tx_start; tx_start is only looked at in IDLE (no queueing).
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic     clk,
  input  logic     reset,
  uart_tx_if.slave bus
);

  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(15);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          r_state, w_state;
  logic [SW-1:0]   r_s, w_s;
  logic [NW-1:0]   r_n, w_n;
  logic [DBIT-1:0] r_b, w_b;
  logic            r_p, w_p;
  logic            r_tx, w_tx;
  logic            w_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_p     <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state;
      r_s     <= w_s;
      r_n     <= w_n;
      r_b     <= w_b;
      r_p     <= w_p;
      r_tx    <= w_tx;
    end
  end

  always_comb begin
    w_state = r_state;
    w_s     = r_s;
    w_n     = r_n;
    w_b     = r_b;
    w_p     = r_p;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tx_start) begin
          w_b     = bus.din;
          w_p     = (PARITY_ODD != 0);
          w_s     = '0;
          w_state = START;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s     = '0;
            w_n     = '0;
            w_state = DATA;
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_p = r_p ^ r_b[0];
            w_b = r_b >> 1;
            w_s = '0;
            if (r_n == N_LAST) begin
              w_state = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              w_n = r_n + NW'(1);
            end
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (r_s == S_BIT_LAST) begin
            w_s     = '0;
            w_state = STOP;
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (r_s == S_STOP_LAST) begin
            w_s     = '0;
            w_done  = 1'b1;
            w_state = IDLE;
          end else begin
            w_s = r_s + SW'(1);
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  // Line level is decoded from the next state so the pin register never glitches.
  always_comb begin
    w_tx = 1'b1;
    case (w_state)
      START:   w_tx = 1'b0;
      DATA:    w_tx = w_b[0];
      PARITY:  w_tx = w_p;
      default: w_tx = 1'b1;
    endcase
  end

  assign bus.tx           = r_tx;
  assign bus.tx_busy      = (r_state != IDLE);
  assign bus.tx_done_tick = w_done & ~reset;

endmodule

// File: tb/tb_uart_tx.sv
// Directed + random frames against a tick-counting line model; dut_a has no parity, dut_b even parity.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       st;
  logic       stick;
  logic       sel;
  logic [7:0] dn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_if #(.DBIT(8)) ifa ();
  uart_tx_if #(.DBIT(8)) ifb ();

  assign ifa.tx_start = st & ~sel;
  assign ifb.tx_start = st & sel;
  assign ifa.s_tick   = stick;
  assign ifb.s_tick   = stick;
  assign ifa.din      = dn;
  assign ifb.din      = dn;

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  function automatic logic cur_tx();
    return sel ? ifb.tx : ifa.tx;
  endfunction
  function automatic logic cur_busy();
    return sel ? ifb.tx_busy : ifa.tx_busy;
  endfunction
  function automatic logic cur_done();
    return sel ? ifb.tx_done_tick : ifa.tx_done_tick;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: after acceptance, the line shows symbol floor(ticks/16) of the frame, stop lasts
  // 16 ticks, done is the clk holding the final tick. Must be entered just after a negedge.
  task automatic run_frame(input logic [7:0] d, input int period, input bit hold,
                           input logic [7:0] d_late);
    int         par;
    int         nbits;
    int         frame;
    int         ticks;
    int         ph;
    int         idx;
    int         guard;
    logic       lv [0:10];
    logic [7:0] rx;
    logic       e_tx;
    par   = sel ? 1 : 0;
    nbits = 1 + 8 + par;
    frame = nbits * 16 + 16;
    ticks = 0;
    ph    = 0;
    guard = 0;
    rx    = 8'h00;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[i+1] = d[i];
    lv[9]  = ^d;
    lv[10] = 1'b1;
    dn    = d;
    st    = 1'b1;
    stick = 1'b1;
    @(posedge clk);
    ph++;
    while (1) begin
      @(negedge clk);
      if (hold) begin
        st = 1'b1;
        dn = d_late;
      end else begin
        st = 1'b0;
      end
      stick = ((ph % period) == 0);
      #1;
      if (ticks >= frame) begin
        chk("idle_tx", cur_tx(), 1'b1);
        chk("idle_busy", cur_busy(), 1'b0);
        chk("idle_done", cur_done(), 1'b0);
        break;
      end
      idx  = ticks / 16;
      e_tx = (idx < nbits) ? lv[idx] : 1'b1;
      chk("tx", cur_tx(), e_tx);
      chk("busy", cur_busy(), 1'b1);
      chk("done", cur_done(), (stick && ticks == frame - 1));
      if (stick && idx >= 1 && idx <= 8 && (ticks % 16) == 8) rx[idx-1] = cur_tx();
      @(posedge clk);
      if (stick) ticks++;
      ph++;
      guard++;
      if (guard > 20000) begin
        chk("frame_timeout", 8'h00, 8'h01);
        break;
      end
    end
    chk("rx_byte", rx, d);
  endtask

  initial begin
    reset = 1'b1;
    st    = 1'b0;
    stick = 1'b1;
    sel   = 1'b0;
    dn    = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_a", ifa.tx, 1'b1);
    chk("rst_busy_a", ifa.tx_busy, 1'b0);
    chk("rst_done_a", ifa.tx_done_tick, 1'b0);
    chk("rst_tx_b", ifb.tx, 1'b1);
    chk("rst_busy_b", ifb.tx_busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    @(negedge clk);
    run_frame(8'hA5, 1, 1'b0, 8'h00);

    @(negedge clk);
    run_frame(8'h3C, 1, 1'b0, 8'h00);
    @(negedge clk);
    run_frame(8'hFF, 1, 1'b0, 8'h00);

    sel = 1'b1;
    @(negedge clk);
    run_frame(8'hA5, 1, 1'b0, 8'h00);
    @(negedge clk);
    run_frame(8'h07, 1, 1'b0, 8'h00);
    sel = 1'b0;

    // Held tx_start: second frame must follow after exactly one idle clk, carrying the late din.
    @(negedge clk);
    run_frame(8'h96, 1, 1'b1, 8'h69);
    run_frame(8'h69, 1, 1'b0, 8'h00);

    // Abort in data bit 3 (ticks 64..79); 8'h52 has bit3 = 0 so the return to 1 is visible.
    @(negedge clk);
    dn    = 8'h52;
    st    = 1'b1;
    stick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    repeat (69) @(negedge clk);
    #1;
    chk("bit3_level", ifa.tx, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_tx", ifa.tx, 1'b1);
    chk("abort_busy", ifa.tx_busy, 1'b0);
    chk("abort_done", ifa.tx_done_tick, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("post_abort_done", ifa.tx_done_tick, 1'b0);
      chk("post_abort_tx", ifa.tx, 1'b1);
    end
    run_frame(8'hE1, 1, 1'b0, 8'h00);

    @(negedge clk);
    run_frame(8'hC3, 10, 1'b0, 8'h00);
    stick = 1'b1;

    for (int k = 0; k < 6; k++) begin
      sel = 1'($urandom_range(0, 1));
      @(negedge clk);
      run_frame(8'($urandom), int'($urandom_range(1, 3)), 1'b0, 8'h00);
    end
    sel   = 1'b0;
    stick = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
